// File: rtl/ysyx_23060061_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, response codes,
// and the instruction substituted for faulting fetches.
package ysyx_23060061_ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] NOP_INST  = 32'h00000013;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one AXI4-Lite style read per
// instruction, and holds the returned word for the decoder until it is consumed.
module ysyx_23060061_ifu
    import ysyx_23060061_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              npc_valid,
    input  logic [ADDR_W-1:0] npc,
    output logic              npc_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic              inst_valid,
    input  logic              inst_ready
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [31:0]       inst_q, inst_d;
    logic              fault_q, fault_d;
    logic              start_q, start_d;
    logic              kill_q, kill_d;
    logic              misaligned;

    assign misaligned = pc_misaligned(pc_q[1:0]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        start_d = start_q;
        kill_d  = kill_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    start_d = 1'b0;
                    state_d = ADDR;
                end else if (start_q) begin
                    start_d = 1'b0;
                    state_d = ADDR;
                end else if (npc_valid) begin
                    pc_d    = npc;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (misaligned) begin
                    // No request is on the bus yet, so a redirect can simply retarget.
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else begin
                        fault_d = 1'b1;
                        inst_d  = NOP_INST;
                        state_d = HOLD;
                    end
                end else begin
                    // arvalid is already up: keep the old address until accepted and
                    // park the new target in rpc_q until the stale response drains.
                    if (redirect) begin
                        kill_d = 1'b1;
                        rpc_d  = redirect_pc;
                    end
                    if (arready) state_d = DATA;
                end
            end
            DATA: begin
                if (redirect) begin
                    kill_d = 1'b1;
                    rpc_d  = redirect_pc;
                end
                if (rvalid) begin
                    if (redirect) begin
                        kill_d  = 1'b0;
                        pc_d    = redirect_pc;
                        state_d = ADDR;
                    end else if (kill_q) begin
                        kill_d  = 1'b0;
                        pc_d    = rpc_q;
                        state_d = ADDR;
                    end else begin
                        inst_d  = rdata;
                        fault_d = (rresp != RESP_OKAY);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ADDR;
                end else if (inst_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            rpc_q   <= RESET_PC;
            inst_q  <= 32'h0;
            fault_q <= 1'b0;
            start_q <= 1'b1;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            start_q <= start_d;
            kill_q  <= kill_d;
        end
    end

    // All bus and decoder outputs come from registered state only.
    assign arvalid    = (state_q == ADDR) && !misaligned;
    assign araddr     = pc_q;
    assign rready     = (state_q == DATA);
    assign inst_valid = (state_q == HOLD);
    assign npc_ready  = (state_q == IDLE) && !start_q && !redirect;
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign inst_fault = fault_q;

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Bench for the fetch unit: behavioural memory slave with programmable delays,
// a scoreboard of expected fetches, a vector table and directed corner sequences.
module tb_ysyx_23060061_ifu;

    localparam logic [31:0] MEM_KEY = 32'h12345678;

    logic        clk, rst;
    logic        npc_valid, npc_ready, redirect;
    logic [31:0] npc, redirect_pc, araddr, rdata, inst, inst_pc;
    logic        arvalid, arready, rvalid, rready, inst_fault, inst_valid, inst_ready;
    logic [1:0]  rresp;

    ysyx_23060061_ifu dut (
        .clk(clk), .rst(rst),
        .npc_valid(npc_valid), .npc(npc), .npc_ready(npc_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] npc;
        int          ar_d;
        int          r_d;
        int          rdy_d;
        logic [1:0]  resp;
        logic [31:0] exp_inst;
        logic        exp_fault;
        int          exp_ar;
    } vec_t;

    exp_t sb[$];
    vec_t vec[7];

    int checks = 0;
    int errors = 0;

    int          ar_delay = 0, r_delay = 0;
    logic [1:0]  cfg_resp = 2'b00;
    int          ar_count = 0, proto_err = 0;
    logic [31:0] last_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h80000000) ? 32'h00100073 : (a ^ MEM_KEY);
    endfunction

    function automatic exp_t model_exp(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.inst  = 32'h00000013;
            e.fault = 1'b1;
        end else begin
            e.inst  = mem_word(pc);
            e.fault = (cfg_resp != 2'b00);
        end
        return e;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory slave: one outstanding read, checks that a pending request stays put.
    initial begin : slave
        logic        pend, prev_wait;
        logic [31:0] paddr, prev_addr;
        int          ar_wait, r_wait;
        pend = 1'b0; prev_wait = 1'b0; paddr = '0; prev_addr = '0;
        ar_wait = 0; r_wait = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            arready = 1'b0;
            rvalid  = 1'b0;
            if (!rst) begin
                pend = 1'b0; prev_wait = 1'b0; ar_wait = 0; r_wait = 0;
            end else begin
                if (prev_wait && (!arvalid || araddr !== prev_addr)) proto_err++;
                prev_wait = 1'b0;
                if (arvalid) begin
                    if (pend) begin
                        proto_err++;
                    end else if (ar_wait >= ar_delay) begin
                        arready = 1'b1; pend = 1'b1; paddr = araddr;
                        ar_count++; last_addr = araddr; ar_wait = 0; r_wait = 0;
                    end else begin
                        ar_wait++; prev_wait = 1'b1; prev_addr = araddr;
                    end
                end else if (pend && rready) begin
                    if (r_wait >= r_delay) begin
                        rvalid = 1'b1; rdata = mem_word(paddr); rresp = cfg_resp; pend = 1'b0;
                    end else begin
                        r_wait++;
                    end
                end
            end
        end
    end

    task automatic issue_npc(input logic [31:0] pc, input exp_t e, input string tag);
        chk1({tag, "_npc_ready"}, npc_ready, 1'b1);
        npc_valid = 1'b1;
        npc       = pc;
        sb.push_back(e);
        tick();
        npc_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!inst_valid && n < 60) begin
            tick();
            n++;
        end
        if (!inst_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout: inst_valid not seen within %0d cycles", tag, n);
        end
    endtask

    task automatic consume(input int rdy_d, input string tag);
        exp_t        e;
        logic [31:0] s_inst, s_pc;
        logic        s_f, stable;
        wait_valid(tag);
        if (inst_valid) begin
            s_inst = inst; s_pc = inst_pc; s_f = inst_fault; stable = 1'b1;
            repeat (rdy_d) begin
                tick();
                if (!inst_valid || inst !== s_inst || inst_pc !== s_pc || inst_fault !== s_f)
                    stable = 1'b0;
            end
            if (rdy_d > 0) chk1({tag, "_stable"}, stable, 1'b1);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s_sb: instruction %h presented with no expectation", tag, inst);
            end else begin
                e = sb.pop_front();
                chk32({tag, "_inst"}, inst, e.inst);
                chk32({tag, "_pc"}, inst_pc, e.pc);
                chk1({tag, "_fault"}, inst_fault, e.fault);
            end
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
            chk1({tag, "_released"}, inst_valid, 1'b0);
        end
    endtask

    task automatic wait_rready(input string tag);
        int n;
        n = 0;
        while (!rready && n < 60) begin
            tick();
            n++;
        end
        if (!rready) begin
            checks++; errors++;
            $display("FAIL %s_timeout: rready not seen within %0d cycles", tag, n);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        sb.delete();
        sb.push_back(model_exp(pc));
        tick();
        redirect = 1'b0;
    endtask

    initial begin : main
        int c0;
        string tag;
        rst = 1'b0; npc_valid = 1'b0; npc = '0; redirect = 1'b0; redirect_pc = '0;
        inst_ready = 1'b0;

        vec[0] = '{32'h80000004, 0, 0, 0, 2'b00, 32'h9234567C, 1'b0, 1};
        vec[1] = '{32'h80000102, 0, 0, 1, 2'b00, 32'h00000013, 1'b1, 0};
        vec[2] = '{32'h80000008, 3, 2, 4, 2'b00, 32'h92345670, 1'b0, 1};
        vec[3] = '{32'h8000000C, 0, 0, 0, 2'b10, 32'h92345674, 1'b1, 1};
        vec[4] = '{32'h80000010, 1, 0, 1, 2'b00, 32'h92345668, 1'b0, 1};
        vec[5] = '{32'h80000021, 0, 0, 0, 2'b00, 32'h00000013, 1'b1, 0};
        vec[6] = '{32'h80000014, 0, 3, 2, 2'b01, 32'h9234566C, 1'b1, 1};

        // Reset values.
        tick(); tick();
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_npc_ready", npc_ready, 1'b0);
        chk32("rst_inst", inst, 32'h0);
        chk32("rst_inst_pc", inst_pc, 32'h80000000);
        chk1("rst_fault", inst_fault, 1'b0);

        // First zero-wait fetch: arvalid cycle 1, rready cycle 2, inst_valid cycle 3.
        rst = 1'b1;
        sb.push_back('{32'h80000000, 32'h00100073, 1'b0});
        chk1("c0_arvalid", arvalid, 1'b0);
        tick();
        chk1("c1_arvalid", arvalid, 1'b1);
        chk32("c1_araddr", araddr, 32'h80000000);
        tick();
        chk1("c2_rready", rready, 1'b1);
        chk1("c2_inst_valid", inst_valid, 1'b0);
        tick();
        chk1("c3_inst_valid", inst_valid, 1'b1);
        consume(0, "first");

        foreach (vec[i]) begin
            tag      = $sformatf("v%0d", i);
            ar_delay = vec[i].ar_d;
            r_delay  = vec[i].r_d;
            cfg_resp = vec[i].resp;
            c0       = ar_count;
            issue_npc(vec[i].npc, '{vec[i].npc, vec[i].exp_inst, vec[i].exp_fault}, tag);
            consume(vec[i].rdy_d, tag);
            chk32({tag, "_ar_count"}, 32'(ar_count - c0), 32'(vec[i].exp_ar));
            if (vec[i].exp_ar != 0) chk32({tag, "_araddr"}, last_addr, vec[i].npc);
        end

        // Redirect while the read is in DATA: the stale word must not surface.
        ar_delay = 0; r_delay = 4; cfg_resp = 2'b00;
        c0 = ar_count;
        issue_npc(32'h80000018, model_exp(32'h80000018), "rd_data");
        wait_rready("rd_data");
        do_redirect(32'h80000100);
        consume(0, "rd_data");
        chk32("rd_data_ar_count", 32'(ar_count - c0), 32'd2);
        chk32("rd_data_araddr", last_addr, 32'h80000100);

        // Redirect while arvalid waits for arready.
        ar_delay = 3; r_delay = 0;
        c0 = ar_count;
        issue_npc(32'h8000001C, model_exp(32'h8000001C), "rd_addr");
        chk1("rd_addr_arvalid", arvalid, 1'b1);
        do_redirect(32'h80000200);
        consume(0, "rd_addr");
        chk32("rd_addr_ar_count", 32'(ar_count - c0), 32'd2);
        chk32("rd_addr_araddr", last_addr, 32'h80000200);

        // Redirect in HOLD drops the held instruction.
        ar_delay = 0;
        c0 = ar_count;
        issue_npc(32'h80000020, model_exp(32'h80000020), "rd_hold");
        wait_valid("rd_hold");
        do_redirect(32'h80000300);
        consume(0, "rd_hold");
        chk32("rd_hold_ar_count", 32'(ar_count - c0), 32'd2);

        // Redirect and npc offered together in IDLE: redirect wins.
        c0 = ar_count;
        npc_valid = 1'b1; npc = 32'h80000400;
        redirect = 1'b1; redirect_pc = 32'h80000500;
        sb.delete();
        sb.push_back(model_exp(32'h80000500));
        #1;
        chk1("both_npc_ready", npc_ready, 1'b0);
        tick();
        npc_valid = 1'b0; redirect = 1'b0;
        consume(0, "both");
        chk32("both_araddr", last_addr, 32'h80000500);

        // Reset asserted mid-DATA.
        r_delay = 5;
        issue_npc(32'h80000024, model_exp(32'h80000024), "mid_rst");
        wait_rready("mid_rst");
        rst = 1'b0;
        #1;
        chk1("mid_rst_arvalid", arvalid, 1'b0);
        chk1("mid_rst_rready", rready, 1'b0);
        chk1("mid_rst_inst_valid", inst_valid, 1'b0);
        tick();
        r_delay = 0;
        sb.delete();
        sb.push_back('{32'h80000000, 32'h00100073, 1'b0});
        c0 = ar_count;
        rst = 1'b1;
        consume(0, "restart");
        chk32("restart_ar_count", 32'(ar_count - c0), 32'd1);
        chk32("restart_araddr", last_addr, 32'h80000000);

        chk32("protocol", 32'(proto_err), 32'd0);
        chk32("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
